rf_multiport: RTL

RF_MULTIPORT -- requirements
Module: rf_multiport

---
 rtl/rf_multiport.sv | 81 ++++++++
 1 files changed

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - two-read/one-write register file with self-init, write-through bypass and debug scan
// Register 0 is hard-wired to zero; contents come only from the INIT sweep and committed writes.
module rf_multiport #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            we,
   input  logic            freeze,
   input  logic [AW-1:0]   wa,
   input  logic [DW-1:0]   wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [DW-1:0]   rd1,
   output logic [DW-1:0]   rd2,
   input  logic            dbg_en,
   output logic [AW-1:0]   dbg_idx,
   output logic [DW-1:0]   dbg_rd,
   output logic            busy,
   output logic [CNTW-1:0] wr_cnt
);

   localparam int NREG = 2 ** AW;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state;
   logic [AW-1:0] icnt;
   logic [DW-1:0] rf [NREG];

   logic run;
   logic init_wr;
   logic commit;

   // Reset overrides RUN combinationally so reads and writes are blocked while rstn is low.
   assign run     = rstn && (state == ST_RUN);
   assign init_wr = rstn && (state == ST_INIT);
   assign commit  = run && we && !freeze && (wa != '0);
   assign busy    = !run;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= ST_INIT;
         icnt    <= '0;
         dbg_idx <= '0;
         wr_cnt  <= '0;
      end else if (state == ST_INIT) begin
         if (icnt == AW'(NREG - 1)) begin
            state <= ST_RUN;
         end
         icnt <= icnt + AW'(1);
      end else begin
         if (commit && (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + CNTW'(1);
         end
         if (dbg_en) begin
            dbg_idx <= dbg_idx + AW'(1);
         end
      end
   end

   // Storage has no reset; the INIT sweep is the only source of initial contents.
   always_ff @(posedge clk) begin
      if (init_wr) begin
         rf[icnt] <= DW'(icnt);
      end else if (commit) begin
         rf[wa] <= wd;
      end
   end

   assign rd1 = (!run || (ra1 == '0)) ? '0 :
                (commit && (ra1 == wa)) ? wd : rf[ra1];
   assign rd2 = (!run || (ra2 == '0)) ? '0 :
                (commit && (ra2 == wa)) ? wd : rf[ra2];

   assign dbg_rd = (!run || (dbg_idx == '0)) ? '0 : rf[dbg_idx];

endmodule
